head_flit_encoder: RTL and testbench



---
 rtl/noc_flit_pkg.sv | 32 +++
 rtl/flit_out_reg.sv | 42 ++++
 rtl/head_flit_encoder.sv | 192 +++++++++++++++++++
 tb/tb_head_flit_encoder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// Shared flit field layout and transmit FSM states for the NoC network interface.
// The router-side head-flit decoder uses the same offsets.
package noc_flit_pkg;

    localparam int NOC_N    = 4;
    localparam int DEST_W   = $clog2(NOC_N);
    localparam int LEN_W    = $clog2(8 + 1);
    localparam int SEQ_W    = 8;
    localparam int DEST_LSB = 0;
    localparam int SRC_LSB  = DEST_W;
    localparam int LEN_LSB  = 2 * DEST_W;
    localparam int SEQ_LSB  = LEN_LSB + LEN_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } flit_state_e;

    // Offsets for blocks elaborated with a node count or body limit other than the defaults
    function automatic int src_lsb(input int dest_w);
        return dest_w;
    endfunction

    function automatic int len_lsb(input int dest_w);
        return 2 * dest_w;
    endfunction

    function automatic int seq_lsb(input int dest_w, input int len_w);
        return 2 * dest_w + len_w;
    endfunction

endpackage

// File: rtl/flit_out_reg.sv
// Valid/ready output holding register: the payload stays stable while the
// consumer stalls, and a new flit may be loaded only when slot_free is high.
module flit_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_flit,
    input  logic             load_tail,
    input  logic             out_ready,
    output logic             slot_free,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_flit,
    output logic             out_tail
);

    logic             valid_r;
    logic [WIDTH-1:0] flit_r;
    logic             tail_r;

    // Holding register: load wins, otherwise a consumed flit drops valid
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            flit_r  <= {WIDTH{1'b0}};
            tail_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            flit_r  <= load_flit;
            tail_r  <= load_tail;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign slot_free = ~valid_r | out_ready;
    assign out_valid = valid_r;
    assign out_flit  = flit_r;
    assign out_tail  = tail_r;

endmodule

// File: rtl/head_flit_encoder.sv
// Transmit-side NI: emits a head flit (dest, source, length[, sequence]) then the body flits.
// Define HEAD_SEQ_NUM_EN to carry an 8-bit per-node packet sequence number in the head flit.
module head_flit_encoder
    import noc_flit_pkg::*;
#(
    parameter int N           = 4,
    parameter int INDEX       = 1,
    parameter int DATA_WIDTH  = 8,
    parameter int PhitPerFlit = 2,
    parameter int MAX_BODY    = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [$clog2(N)-1:0]                cmd_dest,
    input  logic [$clog2(MAX_BODY+1)-1:0]       cmd_len,
    input  logic                                pl_valid,
    output logic                                pl_ready,
    input  logic [PhitPerFlit*DATA_WIDTH-1:0]   pl_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [PhitPerFlit*DATA_WIDTH-1:0]   out_flit,
    output logic                                out_tail,
    output logic                                err_len
);

    localparam int DEST_WIDTH = $clog2(N);
    localparam int LEN_WIDTH  = $clog2(MAX_BODY + 1);
    localparam int FLIT_W     = PhitPerFlit * DATA_WIDTH;
    localparam int SRC_OFS    = src_lsb(DEST_WIDTH);
    localparam int LEN_OFS    = len_lsb(DEST_WIDTH);
    localparam int SEQ_OFS    = seq_lsb(DEST_WIDTH, LEN_WIDTH);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(MAX_BODY);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};

    generate
        if (2 * DEST_WIDTH + LEN_WIDTH > FLIT_W) begin : g_head_too_wide
            $error("head_flit_encoder: dest/src/len fields do not fit in the flit");
        end
    endgenerate

    flit_state_e          state_r, state_nxt_s;
    logic [LEN_WIDTH-1:0] remaining_r, remaining_nxt_s;
    logic [LEN_WIDTH-1:0] eff_len_s;
    logic                 len_over_s;
    logic                 err_len_r;
    logic [FLIT_W-1:0]    head_s;
    logic [FLIT_W-1:0]    load_flit_s;
    logic                 load_s;
    logic                 load_tail_s;
    logic                 slot_free_s;
    logic                 cmd_ready_s;
    logic                 pl_ready_s;
    logic                 cmd_acc_s;

`ifdef HEAD_SEQ_NUM_EN
    logic [SEQ_W-1:0] seq_r;

    generate
        if (SEQ_OFS + SEQ_W > FLIT_W) begin : g_seq_too_wide
            $error("head_flit_encoder: sequence field does not fit in the flit");
        end
    endgenerate

    // Per-node packet sequence number, advanced on every accepted command
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_r <= 8'd0;
        end else if (cmd_acc_s) begin
            seq_r <= seq_r + 8'd1;
        end
    end
`endif

    // Oversized lengths saturate; the head carries the length actually sent
    always_comb begin
        len_over_s = (cmd_len > MAX_LEN);
        if (len_over_s) begin
            eff_len_s = MAX_LEN;
        end else begin
            eff_len_s = cmd_len;
        end
    end

    // Head flit assembly; bits above the populated fields stay zero
    always_comb begin
        head_s                             = {FLIT_W{1'b0}};
        head_s[DEST_LSB +: DEST_WIDTH]     = cmd_dest;
        head_s[SRC_OFS  +: DEST_WIDTH]     = DEST_WIDTH'(INDEX);
        head_s[LEN_OFS  +: LEN_WIDTH]      = eff_len_s;
`ifdef HEAD_SEQ_NUM_EN
        head_s[SEQ_OFS  +: SEQ_W]          = seq_r;
`endif
    end

    // Next-state, handshake and output-load decode
    always_comb begin
        state_nxt_s     = state_r;
        remaining_nxt_s = remaining_r;
        cmd_ready_s     = 1'b0;
        pl_ready_s      = 1'b0;
        cmd_acc_s       = 1'b0;
        load_s          = 1'b0;
        load_flit_s     = {FLIT_W{1'b0}};
        load_tail_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // rst gating keeps both readies low during the reset cycle itself
                cmd_ready_s = slot_free_s & ~rst;
                if (cmd_valid & cmd_ready_s) begin
                    cmd_acc_s       = 1'b1;
                    load_s          = 1'b1;
                    load_flit_s     = head_s;
                    remaining_nxt_s = eff_len_s;
                    if (eff_len_s != LEN_ZERO) begin
                        state_nxt_s = BODY;
                        load_tail_s = 1'b0;
                    end else begin
                        state_nxt_s = IDLE;
                        load_tail_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BODY: begin
                pl_ready_s = slot_free_s & ~rst;
                if (pl_valid & pl_ready_s) begin
                    load_s          = 1'b1;
                    load_flit_s     = pl_data;
                    remaining_nxt_s = remaining_r - LEN_ONE;
                    if (remaining_r == LEN_ONE) begin
                        load_tail_s = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        load_tail_s = 1'b0;
                        state_nxt_s = BODY;
                    end
                end else begin
                    state_nxt_s = BODY;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                remaining_nxt_s = LEN_ZERO;
            end
        endcase
    end

    // FSM state and remaining body-flit count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            remaining_r <= LEN_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            remaining_r <= remaining_nxt_s;
        end
    end

    // Sticky oversize-length flag, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            err_len_r <= 1'b0;
        end else if (cmd_acc_s & len_over_s) begin
            err_len_r <= 1'b1;
        end
    end

    flit_out_reg #(
        .WIDTH(FLIT_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_flit (load_flit_s),
        .load_tail (load_tail_s),
        .out_ready (out_ready),
        .slot_free (slot_free_s),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_tail  (out_tail)
    );

    assign cmd_ready = cmd_ready_s;
    assign pl_ready  = pl_ready_s;
    assign err_len   = err_len_r;

endmodule

// File: tb/tb_head_flit_encoder.sv
// Scoreboard bench for head_flit_encoder: a packet-level model queues expected flits,
// a monitor pops and compares on every out_valid & out_ready handshake.
module tb_head_flit_encoder;

    localparam int N        = 4;
    localparam int INDEX    = 1;
    localparam int MAX_BODY = 8;

    typedef struct packed {
        logic [15:0] flit;
        logic        tail;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_dest  = 2'd0;
    logic [3:0]  cmd_len   = 4'd0;
    logic        pl_valid  = 1'b0;
    logic        pl_ready;
    logic [15:0] pl_data   = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_flit;
    logic        out_tail;
    logic        err_len;

    exp_t        sb[$];
    logic [15:0] fixed_q[$];
    int          n_checks     = 0;
    int          n_fail       = 0;
    int          cyc          = 0;
    int          pop_count    = 0;
    int          last_pop_cyc = 0;
    int          acc_cyc      = 0;
    int          seq_exp      = 0;
    bit          err_exp      = 1'b0;
    bit          rdy_random   = 1'b0;
    int          stall_from   = -10;

    head_flit_encoder #(
        .N(N), .INDEX(INDEX), .DATA_WIDTH(8), .PhitPerFlit(2), .MAX_BODY(MAX_BODY)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest), .cmd_len(cmd_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit), .out_tail(out_tail),
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Router side: ready high, random, or forced low for a 3-cycle window
    initial forever begin
        @(posedge clk);
        #1;
        if (cyc >= stall_from && cyc < stall_from + 3) out_ready = 1'b0;
        else if (rdy_random) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = 1'b1;
    end

    // Monitor: handshake compare, stall stability and stall back-pressure
    initial begin
        exp_t        e;
        logic [15:0] held_flit;
        logic        held_tail;
        bit          hold_pending;
        hold_pending = 1'b0;
        held_flit    = 16'd0;
        held_tail    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_flit", out_flit, held_flit);
                    chk("hold_tail", out_tail, held_tail);
                end
                if (out_valid && !out_ready) begin
                    chk("stall_pl_ready", pl_ready, 0);
                    chk("stall_cmd_ready", cmd_ready, 0);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_flit: got 0x%0h expected no flit", out_flit);
                    end else begin
                        e = sb.pop_front();
                        chk("flit", out_flit, e.flit);
                        chk("tail", out_tail, e.tail);
                    end
                    pop_count++;
                    last_pop_cyc = cyc;
                end
                hold_pending = out_valid && !out_ready;
                held_flit    = out_flit;
                held_tail    = out_tail;
            end
        end
    end

    // Packet-level model plus driver: queue the whole expected flit sequence, then drive it
    task automatic send_packet(input int dest, input int len, input int n_pl, input int gap_max);
        int          eff;
        int          t;
        int          seq_part;
        logic [15:0] d[$];
        logic [15:0] w;
        exp_t        e;
        eff = (len > MAX_BODY) ? MAX_BODY : len;
`ifdef HEAD_SEQ_NUM_EN
        seq_part = seq_exp * 256;
`else
        seq_part = 0;
`endif
        e.flit = 16'(dest + INDEX * 4 + eff * 16 + seq_part);
        e.tail = (eff == 0);
        sb.push_back(e);
        for (int i = 0; i < n_pl; i++) begin
            if (fixed_q.size() != 0) w = fixed_q.pop_front();
            else w = 16'($urandom);
            d.push_back(w);
            e.flit = w;
            e.tail = (i == eff - 1);
            sb.push_back(e);
        end
        cmd_valid = 1'b1;
        cmd_dest  = 2'(dest);
        cmd_len   = 4'(len);
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_accept", cmd_ready, 1);
        acc_cyc = cyc;
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        seq_exp = (seq_exp + 1) % 256;
        if (len > MAX_BODY) err_exp = 1'b1;
        for (int i = 0; i < n_pl; i++) begin
            repeat (gap_max > 0 ? $urandom_range(0, gap_max) : 0) begin
                @(posedge clk);
                #1;
            end
            pl_valid = 1'b1;
            pl_data  = d[i];
            t = 0;
            @(negedge clk);
            while (!pl_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("pl_accept", pl_ready, 1);
            if (!pl_ready) begin
                pl_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            pl_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_in_time", (t < 300), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_cycle_cmd_ready", cmd_ready, 0);
        chk("rst_cycle_pl_ready", pl_ready, 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        err_exp = 1'b0;
        seq_exp = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_flit", out_flit, 0);
        chk("rst_out_tail", out_tail, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_pl_ready", pl_ready, 0);
        chk("after_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pc0;
        int len;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Head + two bodies at full rate
        fixed_q.push_back(16'hAAAA);
        fixed_q.push_back(16'hBBBB);
        pc0 = pop_count;
        send_packet(3, 2, 2, 0);
        drain();
        chk("t1_flit_count", pop_count - pc0, 3);
        chk("t1_last_flit_cycle", last_pop_cyc, acc_cyc + 3);

        // Head-only packet; command port free again on the following cycle
        send_packet(2, 0, 0, 0);
        @(negedge clk);
        chk("head_only_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        drain();

        // Payload offered while idle is not consumed
        pl_valid = 1'b1;
        pl_data  = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            chk("idle_pl_ready", pl_ready, 0);
            chk("idle_out_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        pl_valid = 1'b0;

        // Router stalls 3 cycles while the first body flit is presented
        stall_from = cyc + 2;
        send_packet(0, 3, 3, 0);
        drain();
        stall_from = -10;

        // Oversized length saturates and sets the sticky error
        send_packet(1, 12, 8, 1);
        drain();
        chk("err_len_set", err_len, 1);
        send_packet(3, 1, 1, 0);
        drain();
        chk("err_len_sticky", err_len, 1);

        // Abort a 4-body packet after head + 1 body, then start fresh
        send_packet(2, 4, 1, 0);
        drain();
        do_reset();
        send_packet(2, 1, 1, 0);
        drain();

        // Random traffic with random back-pressure
        rdy_random = 1'b1;
        for (int i = 0; i < 40; i++) begin
            len = $urandom_range(0, 11);
            send_packet($urandom_range(0, 3), len, (len > MAX_BODY) ? MAX_BODY : len, $urandom_range(0, 2));
            drain();
            chk("err_len_model", err_len, err_exp);
        end
        rdy_random = 1'b0;

        // 257 back-to-back head-only packets: sequence field wraps once
        do_reset();
        for (int i = 0; i < 257; i++) send_packet(i % 4, 0, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
